// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Round-robin arbiter and frame sequencer for the SPI master bit lane.
//   Grants the shared lane to one requester, walks the lane phase counter
//   through one frame, and drives per-device slave selects and SCLK.
//
//   Parameters:
//     BYTES   - bytes per frame (frame = 8*BYTES+2 bits), must match lane
//     NREQ    - number of requesters / slaves (1..8)
//     GAP_CYC - idle clocks with all ss_n high between frames (1..15)
//
//   Ports:
//     clk      - bit clock shared with the lane
//     reset_n  - asynchronous active-low reset
//     req      - per-requester frame request (level, held until done)
//     gnt      - one-hot grant, stable from SETUP through DONE
//     cnt      - phase counter to the lane
//     sclk     - SPI clock, idle low
//     ss_n     - active-low slave selects
//     done     - one-cycle pulse, lane sdat valid
//     busy     - high whenever a frame or inter-frame gap is in progress
//
//   Build option: define SPI_ARB_PRIORITY_EN for fixed priority (lowest set
//   req index wins, no rotating pointer); default is round-robin.
module spi_master_arbiter #(
  parameter int BYTES   = 1,
  parameter int NREQ    = 2,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [BYTES+3:0] cnt,
  output logic             sclk,
  output logic [NREQ-1:0]  ss_n,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CW = BYTES + 4;
  localparam int unsigned NR = NREQ;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * (8 * BYTES + 2) - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_t;

  state_t          state, state_d;
  logic [3:0]      gap_cnt, gap_cnt_d;
  logic [NREQ-1:0] gnt_d, ss_n_d;
  logic [CW-1:0]   cnt_d;
  logic            sclk_d, done_d, busy_d;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;

`ifdef SPI_ARB_PRIORITY_EN
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!sel_found && req[IW'(i)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr, ptr_d;

  // Search begins at ptr (one past the last grant) and wraps to index 0.
  always_comb begin
    int unsigned idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NR) idx = idx - NR;
      if (!sel_found && req[IW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr;
    if (state == S_IDLE && sel_found) begin
      if (32'(sel_idx) == NR - 1) ptr_d = '0;
      else                        ptr_d = sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr <= '0;
    else          ptr <= ptr_d;
  end
`endif

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
      gnt     <= '0;
      ss_n    <= '1;
      cnt     <= '0;
      sclk    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      gap_cnt <= gap_cnt_d;
      gnt     <= gnt_d;
      ss_n    <= ss_n_d;
      cnt     <= cnt_d;
      sclk    <= sclk_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

  // Next-state logic; cnt doubles as the SHIFT length counter.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (sel_found) state_d = S_SETUP;
      S_SETUP: state_d = S_SHIFT;
      S_SHIFT: if (cnt == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_GAP;
      S_GAP:   if (gap_cnt == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. ss_n, sclk and done are loaded from the state being left,
  // so they trail the state by one clock: ss_n falls one clock after SETUP
  // is entered and done pulses in the first GAP clock.
  always_comb begin
    gnt_d     = gnt;
    ss_n_d    = '1;
    cnt_d     = '0;
    sclk_d    = 1'b0;
    done_d    = 1'b0;
    gap_cnt_d = '0;
    busy_d    = (state_d != S_IDLE);
    unique case (state)
      S_IDLE: begin
        gnt_d = '0;
        if (sel_found) gnt_d[sel_idx] = 1'b1;
      end
      S_SETUP: ss_n_d = ~gnt;
      S_SHIFT: begin
        ss_n_d = ~gnt;
        sclk_d = ~cnt[0];
        cnt_d  = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        gnt_d  = '0;
      end
      S_GAP: begin
        gnt_d     = '0;
        gap_cnt_d = gap_cnt + 1'b1;
      end
      default: gnt_d = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;

  localparam int A_NB = 20;  // 2*BITS for BYTES=1
  localparam int B_NB = 36;  // 2*BITS for BYTES=2

  logic       clk = 1'b0;
  logic       reset_n;

  logic [1:0] req_a, gnt_a, ss_n_a;
  logic [4:0] cnt_a;
  logic       sclk_a, done_a, busy_a;

  logic [2:0] req_b, gnt_b, ss_n_b;
  logic [5:0] cnt_b;
  logic       sclk_b, done_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_arbiter #(.BYTES(1), .NREQ(2), .GAP_CYC(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .gnt(gnt_a), .cnt(cnt_a),
    .sclk(sclk_a), .ss_n(ss_n_a), .done(done_a), .busy(busy_a)
  );

  spi_master_arbiter #(.BYTES(2), .NREQ(3), .GAP_CYC(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .gnt(gnt_b), .cnt(cnt_b),
    .sclk(sclk_b), .ss_n(ss_n_b), .done(done_b), .busy(busy_b)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    req_a   = '0;
    req_b   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gnt_a, ss_n_a, cnt_a, sclk_a, done_a, busy_a} !== {2'b00, 2'b11, 5'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_a: gnt=%b ss_n=%b cnt=%0d sclk=%b done=%b busy=%b, want 00 11 0 0 0 0",
               gnt_a, ss_n_a, cnt_a, sclk_a, done_a, busy_a);
    end
    checks++;
    if ({gnt_b, ss_n_b, cnt_b, sclk_b, done_b, busy_b} !== {3'b000, 3'b111, 6'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_b: gnt=%b ss_n=%b cnt=%0d sclk=%b done=%b busy=%b, want 000 111 0 0 0 0",
               gnt_b, ss_n_b, cnt_b, sclk_b, done_b, busy_b);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || gnt_a !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b gnt=%b, want 0 00", busy_a, gnt_a);
    end
  endtask

  // One frame from requester 0; every output checked on every clock.
  task automatic test_single();
    int pulses = 0;
    logic [1:0] eg, es;
    logic [4:0] ec;
    logic ek, ed, eb;
    req_a = 2'b01;
    for (int c = 0; c <= 25; c++) begin
      @(posedge clk);
      #1;
      eg = (c <= A_NB + 1) ? 2'b01 : 2'b00;
      es = (c >= 1 && c <= A_NB + 1) ? 2'b10 : 2'b11;
      ec = (c >= 1 && c <= A_NB) ? 5'(c - 1) : 5'd0;
      ek = (c >= 2 && c <= A_NB && (c % 2) == 0);
      ed = (c == A_NB + 2);
      eb = (c <= A_NB + 3);
      if (sclk_a) pulses++;
      checks++;
      if ({gnt_a, ss_n_a, cnt_a, sclk_a, done_a, busy_a} !== {eg, es, ec, ek, ed, eb}) begin
        errors++;
        $display("FAIL single c=%0d: gnt=%b ss_n=%b cnt=%0d sclk=%b done=%b busy=%b, want %b %b %0d %b %b %b",
                 c, gnt_a, ss_n_a, cnt_a, sclk_a, done_a, busy_a, eg, es, ec, ek, ed, eb);
      end
      if (c == A_NB + 2) req_a = 2'b00;
    end
    checks++;
    if (pulses !== 10) begin
      errors++;
      $display("FAIL single_sclk_pulses: got %0d want 10", pulses);
    end
  endtask

  // Both requesters held: grants rotate, one frame every 25 clocks.
  task automatic test_contention();
    logic [1:0] prev, eg;
    logic [1:0] seen[4];
    int rise_t[4];
    int n = 0;
    int t;
    req_a = 2'b11;
    prev  = gnt_a;
    for (int c = 0; c < 110 && n < 4; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ($countones(gnt_a) > 1) begin
        errors++;
        $display("FAIL contention_onehot c=%0d: gnt=%b, want at most one bit", c, gnt_a);
      end
      if (prev == 2'b00 && gnt_a != 2'b00) begin
        seen[n]   = gnt_a;
        rise_t[n] = c;
        n++;
      end
      prev = gnt_a;
    end
    req_a = 2'b00;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL contention_count: got %0d grants want 4", n);
    end
    for (int i = 0; i < n; i++) begin
`ifdef SPI_ARB_PRIORITY_EN
      eg = 2'b01;
`else
      eg = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
      checks++;
      if (seen[i] !== eg) begin
        errors++;
        $display("FAIL contention_gnt%0d: got %b want %b", i, seen[i], eg);
      end
      if (i > 0) begin
        t = rise_t[i] - rise_t[i-1];
        checks++;
        if (t !== 25) begin
          errors++;
          $display("FAIL contention_period%0d: got %0d want 25", i, t);
        end
      end
    end
    t = 0;
    while (busy_a && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle: busy=%b want 0", busy_a);
    end
  endtask

  // Async reset in the middle of SHIFT, then a clean restart.
  task automatic test_reset_mid();
    bit found = 0;
    bit got_done = 0;
    int t = 0;
    req_a = 2'b11;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk);
      #1;
      if (cnt_a == 5'd7) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_reach_cnt7: got cnt=%0d want 7", cnt_a);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt_a, ss_n_a, cnt_a, sclk_a, done_a, busy_a} !== {2'b00, 2'b11, 5'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid_async: gnt=%b ss_n=%b cnt=%0d sclk=%b done=%b busy=%b, want 00 11 0 0 0 0",
               gnt_a, ss_n_a, cnt_a, sclk_a, done_a, busy_a);
    end
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({gnt_a, ss_n_a, cnt_a, done_a, busy_a} !== {2'b01, 2'b11, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL restart_setup: gnt=%b ss_n=%b cnt=%0d done=%b busy=%b, want 01 11 0 0 1",
               gnt_a, ss_n_a, cnt_a, done_a, busy_a);
    end
    req_a = 2'b01;
    @(posedge clk);
    #1;
    checks++;
    if ({ss_n_a, cnt_a} !== {2'b10, 5'd0}) begin
      errors++;
      $display("FAIL restart_ss: ss_n=%b cnt=%0d, want 10 0", ss_n_a, cnt_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt_a !== 5'd1) begin
      errors++;
      $display("FAIL restart_cnt1: cnt=%0d want 1", cnt_a);
    end
    while (!got_done && t < 30) begin
      @(posedge clk);
      #1;
      if (done_a) got_done = 1;
      t++;
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL restart_done: done not seen within 30 clocks, want pulse");
    end
    req_a = 2'b00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Request withdrawn mid-frame: frame still completes with one done.
  task automatic test_drop();
    bit found = 0;
    int dones = 0;
    int done_at = -1;
    int idle_at = -1;
    logic [4:0] maxc;
    req_a = 2'b01;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge clk);
      #1;
      if (cnt_a == 5'd4) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drop_reach_cnt4: got cnt=%0d want 4", cnt_a);
    end
    req_a = 2'b00;
    maxc  = cnt_a;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        dones++;
        done_at = c;
      end
      if (cnt_a > maxc) maxc = cnt_a;
      if (!busy_a && idle_at < 0) idle_at = c;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL drop_done_count: got %0d want 1", dones);
    end
    checks++;
    if (done_at !== 17) begin
      errors++;
      $display("FAIL drop_done_time: got %0d want 17", done_at);
    end
    checks++;
    if (maxc !== 5'd19) begin
      errors++;
      $display("FAIL drop_max_cnt: got %0d want 19", maxc);
    end
    checks++;
    if (idle_at !== 19) begin
      errors++;
      $display("FAIL drop_idle_time: got %0d want 19", idle_at);
    end
  endtask

  // Two-byte, three-requester, one-gap-clock instance.
  task automatic test_bytes2();
    int pulses = 0;
    logic [2:0] eg, es;
    logic [5:0] ec;
    logic ed, eb;
    req_b = 3'b100;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk);
      #1;
      eg = (c <= B_NB + 1) ? 3'b100 : 3'b000;
      es = (c >= 1 && c <= B_NB + 1) ? 3'b011 : 3'b111;
      ec = (c >= 1 && c <= B_NB) ? 6'(c - 1) : 6'd0;
      ed = (c == B_NB + 2);
      eb = (c <= B_NB + 2);
      if (sclk_b) pulses++;
      checks++;
      if ({gnt_b, ss_n_b, cnt_b, done_b, busy_b} !== {eg, es, ec, ed, eb}) begin
        errors++;
        $display("FAIL bytes2 c=%0d: gnt=%b ss_n=%b cnt=%0d done=%b busy=%b, want %b %b %0d %b %b",
                 c, gnt_b, ss_n_b, cnt_b, done_b, busy_b, eg, es, ec, ed, eb);
      end
      if (c == B_NB + 2) req_b = 3'b000;
    end
    checks++;
    if (pulses !== 18) begin
      errors++;
      $display("FAIL bytes2_sclk_pulses: got %0d want 18", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_reset_mid();
    test_drop();
    test_bytes2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Sequencing controller and round-robin arbiter for the SPI master bit-lane datapath. Grants the shared bus to one of NREQ requesters, drives the lane's `cnt` phase counter through exactly one frame, and generates per-device active-low slave selects and SCLK. Signals completion so the granted requester samples `sdat` and presents its next `mdat`.

## Interface
- `BYTES`, 1: bytes per frame; must match the lane instance. Frame length BITS = 8*BYTES+2.
- `NREQ`, 2: number of requesters/slaves, 1..8.
- `GAP_CYC`, 2: minimum clocks with all `ss_n` high between frames, 1..15.
- `clk` in 1: bit clock, shared with the lane.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req` in NREQ: per-requester frame request, level; held until its `done`.
- `gnt` out NREQ: one-hot grant; stable from SETUP through DONE.
- `cnt` out BYTES+4: phase counter to lane `cnt`.
- `sclk` out 1: SPI clock, idle low.
- `ss_n` out NREQ: slave selects, active-low; bit i low only while `gnt[i]`.
- `done` out 1: one-cycle pulse; lane `sdat` valid this cycle.
- `busy` out 1: high in SETUP, SHIFT, DONE, GAP.

## Operation
- States: IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE: `cnt`=0, `gnt`=0, `ss_n` all 1, `sclk`=0. If any `req` bit set, arbitrate, load `gnt`, go SETUP.
- Round-robin: search starts at index after last granted, wraps at NREQ-1 -> 0; pointer updated only on grant. After reset pointer selects index 0 first.
- SETUP (1 cycle): `ss_n[g]` driven low, `cnt` stays 0, go SHIFT.
- SHIFT: `cnt` increments 0 -> 2*BITS-1 one per clock; odd `cnt` updates lane `mosi`, even `cnt` shifts `miso`. At `cnt`=2*BITS-1 go DONE.
- DONE (1 cycle): `done`=1, `cnt` returns 0, `ss_n` all high, `sclk`=0; go GAP.
- GAP: `gnt` cleared on entry; count GAP_CYC clocks, then IDLE (arbitration next cycle).
- `sclk` registered: next `sclk` = 1 when state is SHIFT and `cnt[0]`=0, else 0.
- `req` dropped mid-frame: ignored; frame completes, `done` still pulses.
- `req` bit of granted requester still high after DONE: treated as new request, subject to round-robin.
- Only one frame outstanding; no queuing beyond `req` levels.

## Timing
- Reset values: `cnt`=0, `gnt`=0, `ss_n`=all 1, `sclk`=0, `done`=0, `busy`=0, pointer=0; state IDLE. Assertion of `reset_n` mid-frame returns to these immediately (async); no `done` emitted.
- `req` seen in IDLE at edge k -> `gnt`, `busy` high after edge k; `ss_n` low after edge k+1; `cnt`=1 after edge k+2.
- Frame: SETUP 1 + SHIFT 2*BITS + DONE 1 cycles; `done` high 2*BITS+2 cycles after `gnt` rises.
- Back-to-back minimum period: 2*BITS + 3 + GAP_CYC clocks (IDLE 1 cycle).
- `cnt` width BYTES+4 holds 2*BITS-1 for all BYTES>=1; no wrap.

## Configuration
- `SPI_ARB_PRIORITY_EN` defined: fixed priority, lowest set `req` index always wins; pointer logic removed.
- Undefined (default): round-robin as above.

## Test plan
- Single request, BYTES=1: `req`=2'b01 -> `gnt`=01, `ss_n`=10 for 21 cycles, `cnt` 0..19, 10 `sclk` pulses, `done` at cycle 22 with slave echo `sdat` matching expected 10-bit frame.
- Contention: `req`=2'b11 held -> grants alternate 01,10,01,10; each frame 23+GAP_CYC clocks apart; never two `gnt` bits set.
- `SPI_ARB_PRIORITY_EN` build, `req`=2'b11 held -> `gnt`=01 every frame, requester 1 starved.
- Reset mid-SHIFT at `cnt`=7 -> `ss_n` all 1, `cnt`=0, `gnt`=0 within same time step; no `done`; next `req` starts clean SETUP.
- `req` dropped at `cnt`=4 -> frame runs to `cnt`=19, `done` pulses once, returns IDLE after GAP_CYC.
- BYTES=2, NREQ=3, GAP_CYC=1: `req`=3'b100 -> `cnt` 0..35, 18 `sclk` pulses, `ss_n`=011, `done` 38 cycles after `gnt`.
